rib_dtcm_slave: RTL and testbench

Data tightly-coupled memory on the RIB bus: the slave endpoint that consumes the load/store unit's RIB master requests.
- Single-port, word-organised SRAM with byte-mask writes and registered reads.
- In-order responses through a 2-entry response buffer, so the LSU can issue back-to-back requests (misaligned two-beat accesses) before the first response returns.
- Sits behind the RIB interconnect's address decode; only word-index address bits are used.

---
 rtl/rib_dtcm_slave_pkg.sv | 7 +
 rtl/rib_dtcm_slave_sram.sv | 32 +++
 rtl/rib_dtcm_slave.sv | 110 +++++++++++
 tb/tb_rib_dtcm_slave.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rib_dtcm_slave_pkg.sv
// Shared RIB field widths and response-buffer sizing for the DTCM slave.
package rib_dtcm_slave_pkg;
    localparam int RIB_ADDR_W    = 32;
    localparam int RIB_DATA_W    = 32;
    localparam int RIB_MASK_W    = 4;
    localparam int RSP_BUF_DEPTH = 2;
endpackage

// File: rtl/rib_dtcm_slave_sram.sv
// Single-port byte-write array with a synchronous read; a foundry macro can drop in here.
module dtcm_sram_1rw
    import rib_dtcm_slave_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [RIB_MASK_W-1:0] we,
    input  logic [AW-1:0]         addr,
    input  logic [RIB_DATA_W-1:0] wdata,
    output logic [RIB_DATA_W-1:0] rdata
);

    logic [RIB_DATA_W-1:0] mem [DEPTH];

    // rdata only updates on reads so a write never disturbs a pending read result.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < RIB_MASK_W; k++) begin
                if (we[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
            if (we == '0) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/rib_dtcm_slave.sv
// RIB slave front end for the DTCM: grant, one pending access, 2-entry in-order response buffer.
module rib_dtcm_slave
    import rib_dtcm_slave_pkg::*;
#(
    parameter int DEPTH = 4096,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_ribs_req,
    output logic                  o_ribs_gnt,
    input  logic [RIB_ADDR_W-1:0] i_ribs_addr,
    input  logic                  i_ribs_wrcs,
    input  logic [RIB_MASK_W-1:0] i_ribs_mask,
    input  logic [RIB_DATA_W-1:0] i_ribs_wdata,
    output logic                  o_ribs_rsp,
    output logic [RIB_DATA_W-1:0] o_ribs_rdata,
    input  logic                  i_ribs_rdy
);

    logic                  live;
    logic                  p;
    logic                  wr_p;
    logic [1:0]            cnt;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [RIB_DATA_W-1:0] rsp_buf [RSP_BUF_DEPTH];

    logic                  accept;
    logic                  pop;
    logic                  pop_buf;
    logic                  push;
    logic [1:0]            occ;
    logic [1:0]            occ_after;
    logic [AW-1:0]         word_idx;
    logic [RIB_MASK_W-1:0] sram_we;
    logic [RIB_DATA_W-1:0] sram_rdata;
    logic [RIB_DATA_W-1:0] p_data;
    logic                  unused_addr;

    assign word_idx    = i_ribs_addr[AW+1:2];
    assign unused_addr = ^{i_ribs_addr[RIB_ADDR_W-1:AW+2], i_ribs_addr[1:0]};

    assign occ       = cnt + {1'b0, p};
    assign occ_after = occ - {1'b0, pop};
    // live holds grant low while in reset and for the first edge after release.
    assign o_ribs_gnt = live & (occ_after < 2'(RSP_BUF_DEPTH));

    assign accept  = i_ribs_req & o_ribs_gnt;
    assign pop     = o_ribs_rsp & i_ribs_rdy;
    assign pop_buf = pop & (cnt != 2'd0);
    assign push    = p & ((cnt != 2'd0) | ~pop);
    assign p_data  = wr_p ? '0 : sram_rdata;
    assign sram_we = i_ribs_wrcs ? i_ribs_mask : '0;

    dtcm_sram_1rw #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (i_clk),
        .en    (accept),
        .we    (sram_we),
        .addr  (word_idx),
        .wdata (i_ribs_wdata),
        .rdata (sram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            live   <= 1'b0;
            p      <= 1'b0;
            wr_p   <= 1'b0;
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            live <= 1'b1;
            p    <= accept;
            if (accept) begin
                wr_p <= i_ribs_wrcs;
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_buf) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop_buf};
        end
    end

    // Buffer payload needs no reset; occupancy is tracked by cnt.
    always_ff @(posedge i_clk) begin
        if (push) begin
            rsp_buf[wr_ptr] <= p_data;
        end
    end

    assign o_ribs_rsp = (cnt != 2'd0) | p;

    always_comb begin
        o_ribs_rdata = '0;
        if (cnt != 2'd0) begin
            o_ribs_rdata = rsp_buf[rd_ptr];
        end else if (p) begin
            o_ribs_rdata = p_data;
        end
    end

endmodule

// File: tb/tb_rib_dtcm_slave.sv
// Directed bench for rib_dtcm_slave: expected responses queued at grant, checked by a monitor.
module tb_rib_dtcm_slave;

    logic        clk;
    logic        rstn;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        wrcs;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        rsp;
    logic [31:0] rdata;
    logic        rdy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];

    rib_dtcm_slave #(.DEPTH(16)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_ribs_req   (req),
        .o_ribs_gnt   (gnt),
        .i_ribs_addr  (addr),
        .i_ribs_wrcs  (wrcs),
        .i_ribs_mask  (mask),
        .i_ribs_wdata (wdata),
        .o_ribs_rsp   (rsp),
        .o_ribs_rdata (rdata),
        .i_ribs_rdy   (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] wd, input logic [31:0] exp, output int waited);
        waited = 0;
        req = 1'b1; wrcs = wr; addr = a; mask = m; wdata = wd;
        #1;
        while (!gnt && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!gnt) begin
            check("grant_timeout", 32'(gnt), 32'd1);
            req = 1'b0;
        end else begin
            exp_q.push_back(exp);
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares each popped response and checks data holds while stalled.
    initial begin
        logic [31:0] held;
        logic        holding;
        holding = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rstn) begin
                holding = 1'b0;
            end else begin
                if (holding && rsp) check("hold_stable", rdata, held);
                holding = 1'b0;
                if (rsp && rdy) begin
                    if (exp_q.size() == 0) check("unexpected_rsp", 32'(rsp), 32'd0);
                    else check("rsp_data", rdata, exp_q.pop_front());
                end else if (rsp) begin
                    holding = 1'b1;
                    held = rdata;
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rstn = 1'b0; req = 1'b0; wrcs = 1'b0; addr = '0; mask = '0; wdata = '0; rdy = 1'b1;
        #2;
        check("reset_rsp",   32'(rsp), 32'd0);
        check("reset_rdata", rdata,    32'd0);
        check("reset_gnt",   32'(gnt), 32'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("gnt_after_reset", 32'(gnt), 32'd1);

        // 1: write then immediate read of the same word
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, w);
        check("wr_rsp_latency", 32'(rsp), 32'd1);
        check("wr_rsp_rdata",   rdata,    32'd0);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, w);
        check("rd_rsp_latency", 32'(rsp), 32'd1);
        check("rd_raw_rdata",   rdata,    32'hDEADBEEF);

        // 2: partial mask, then an empty mask that must change nothing
        issue(1'b1, 32'h10, 4'b0110, 32'h00AABB00, 32'h0, w);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAABBEF, w);
        issue(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'h0, w);
        issue(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAABBEF, w);

        // 3: back-to-back reads, granted without stalls, consecutive responses
        issue(1'b1, 32'h20, 4'hF, 32'h11111111, 32'h0, w);
        issue(1'b1, 32'h24, 4'hF, 32'h22222222, 32'h0, w);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h11111111, w);
        check("b2b_wait0", 32'(w), 32'd0);
        check("b2b_rsp0",  rdata, 32'h11111111);
        issue(1'b0, 32'h24, 4'h0, 32'h0, 32'h22222222, w);
        check("b2b_wait1", 32'(w), 32'd0);
        check("b2b_rsp1",  rdata, 32'h22222222);
        wait_drain();

        // 4: fill the buffer with rdy low, third request stalls until the first pop
        rdy = 1'b0;
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAABBEF, w);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h11111111, w);
        fork
            issue(1'b0, 32'h24, 4'h0, 32'h0, 32'h22222222, w);
            begin
                #1;
                check("gnt_full", 32'(gnt), 32'd0);
                @(negedge clk);
                #1;
                check("gnt_full_hold", 32'(gnt), 32'd0);
                @(negedge clk);
                rdy = 1'b1;
                #1;
                check("gnt_full_pop", 32'(gnt), 32'd1);
                check("rsp_head",     rdata,    32'hDEAABBEF);
            end
        join
        check("third_wait", 32'(w), 32'd2);
        wait_drain();

        // 5: reset with two responses outstanding discards them
        rdy = 1'b0;
        issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h11111111, w);
        issue(1'b0, 32'h24, 4'h0, 32'h0, 32'h22222222, w);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_rsp", 32'(rsp), 32'd0);
        check("rst_mid_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'h24, 4'h0, 32'h0, 32'h22222222, w);
        wait_drain();
        repeat (3) @(negedge clk);
        check("no_stale_rsp", 32'(rsp), 32'd0);

        // 6: address wrap with DEPTH=16
        issue(1'b1, 32'h40, 4'hF, 32'h00000055, 32'h0, w);
        issue(1'b0, 32'h00, 4'h0, 32'h0, 32'h00000055, w);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAABBEF, w);
        wait_drain();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
